// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flip-flop
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] sa, sb, res;
   logic [CW-1:0] cnt;
   logic br, d, nbr, last;
   assign d = sa[0] ^ sb[0] ^ br;
   assign nbr = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa <= '0;
         sb <= '0;
         res <= '0;
         cnt <= '0;
         br <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sa <= a;
               sb <= b;
               br <= bin;
               cnt <= '0;
               state <= RUN;
            end
            RUN: begin
               sa <= sa >> 1;
               sb <= sb >> 1;
               res <= {d, res[WIDTH-1:1]};
               br <= nbr;
               cnt <= last ? cnt : cnt + 1'b1;
               if (last) begin
                  diff <= {d, res[WIDTH-1:1]};
                  bout <= nbr;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor at WIDTH=4 and WIDTH=8
module tb_serial_subtractor;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic s4 = 1'b0, bi4 = 1'b0, busy4, done4, bo4;
   logic [3:0] a4 = '0, b4 = '0, d4;
   logic s8 = 1'b0, bi8 = 1'b0, busy8, done8, bo8;
   logic [7:0] a8 = '0, b8 = '0, d8;
   int checks = 0, errors = 0;

   serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .bin(bi4),
      .busy(busy4), .done(done4), .diff(d4), .bout(bo4));
   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bi8),
      .busy(busy8), .done(done8), .diff(d8), .bout(bo8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {bout, diff}: true signed difference, reduced modulo 2^w, borrow when negative
   function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin);
      longint r;
      logic [31:0] mask;
      r = longint'(a) - longint'(b) - longint'(bin);
      mask = (32'd1 << w) - 32'd1;
      return {r < 0 ? 1'b1 : 1'b0, 32'(r) & mask};
   endfunction

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi, input string tag);
      logic [32:0] m;
      int n;
      m = model(4, 32'(a), 32'(b), bi);
      @(negedge clk); s4 = 1'b1; a4 = a; b4 = b; bi4 = bi;
      @(negedge clk); s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom);
      chk({tag, " busy"}, 32'(busy4), 32'd1);
      n = 1;
      while (done4 !== 1'b1 && n < 12) begin @(negedge clk); n++; end
      chk({tag, " latency"}, n, 5);
      chk({tag, " diff"}, 32'(d4), m[31:0]);
      chk({tag, " bout"}, 32'(bo4), 32'(m[32]));
      @(negedge clk);
      chk({tag, " idle"}, {30'd0, busy4, done4}, 32'd0);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi);
      logic [32:0] m;
      int n;
      m = model(8, 32'(a), 32'(b), bi);
      @(negedge clk); s8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
      @(negedge clk); s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      n = 1;
      while (done8 !== 1'b1 && n < 16) begin @(negedge clk); n++; end
      chk("w8 latency", n, 9);
      chk("w8 result", {23'd0, bo8, d8}, {23'd0, m[32], m[7:0]});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int nd;
      logic [3:0] cur_d;
      logic cur_b;
      logic [32:0] m;
      logic [3:0] ta [3];
      logic [3:0] tb [3];
      int idx;
      repeat (3) @(negedge clk);
      chk("reset w4", {25'd0, busy4, done4, bo4, d4}, 32'd0);
      chk("reset w8", {21'd0, busy8, done8, bo8, d8}, 32'd0);
      rst = 1'b0;
      run4(4'd9, 4'd3, 1'b0, "t1");
      run4(4'd3, 4'd9, 1'b0, "t2a");
      run4(4'd0, 4'd0, 1'b1, "t2b");
      run4(4'hF, 4'hF, 1'b0, "t2c");
      // start issued mid-run must be ignored
      @(negedge clk); s4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bi4 = 1'b0;
      @(negedge clk); s4 = 1'b0;
      @(negedge clk); s4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      @(negedge clk); s4 = 1'b0;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) nd++;
      end
      chk("t3 done count", nd, 1);
      chk("t3 diff", 32'(d4), 32'd6);
      chk("t3 bout", 32'(bo4), 32'd0);
      chk("t3 busy", 32'(busy4), 32'd0);
      // reset mid-run aborts
      @(negedge clk); s4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
      @(negedge clk); s4 = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("t4 after rst", {29'd0, busy4, done4, bo4}, 32'd0);
      chk("t4 diff", 32'(d4), 32'd0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done4 === 1'b1) nd++;
      end
      chk("t4 no done", nd, 0);
      run4(4'd7, 4'd2, 1'b0, "t4b");
      // continuous start: one completion every WIDTH+2 cycles
      ta[0] = 4'd9; tb[0] = 4'd3;
      ta[1] = 4'd10; tb[1] = 4'd3;
      ta[2] = 4'd2; tb[2] = 4'd5;
      cur_d = 4'd5; cur_b = 1'b0; idx = 0;
      @(negedge clk); s4 = 1'b1; a4 = ta[0]; b4 = tb[0]; bi4 = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 5 || k == 11 || k == 17) begin
            m = model(4, 32'(ta[idx]), 32'(tb[idx]), 1'b0);
            cur_d = m[3:0]; cur_b = m[32];
            chk("t5 done", 32'(done4), 32'd1);
            idx++;
            if (idx < 3) begin a4 = ta[idx]; b4 = tb[idx]; end
         end else begin
            chk("t5 no done", 32'(done4), 32'd0);
         end
         chk("t5 diff", {27'd0, cur_b, d4}, {27'd0, bo4, cur_d});
         chk("t5 diff hold", 32'(d4), 32'(cur_d));
      end
      s4 = 1'b0;
      @(negedge clk);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               run4(4'(a), 4'(b), 1'(c), "sweep");
      for (int i = 0; i < 1000; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
